// File: rtl/rf_multiport_sb_pkg.sv
// rtl/rf_multiport_sb_pkg.sv - shared types for the multi-port register file
// Clear-engine state encoding shared by the FSM and the top level.
package rf_multiport_sb_pkg;

  typedef enum logic {
    RF_ST_CLEAR = 1'b0,
    RF_ST_RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/rf_multiport_sb_if.sv
// rtl/rf_multiport_sb_if.sv - decode/writeback bus of the register file
// Master is the pipeline side, slave is the register file.
interface rf_multiport_sb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2
);
  logic                         clear_req;
  logic                         ready;
  logic [NUM_WR-1:0]            wen;
  logic [NUM_WR*ADDR_WIDTH-1:0] waddr;
  logic [NUM_WR*DATA_WIDTH-1:0] wdata;
  logic                         alloc_en;
  logic [ADDR_WIDTH-1:0]        alloc_addr;
  logic [NUM_RD*ADDR_WIDTH-1:0] raddr;
  logic [NUM_RD*DATA_WIDTH-1:0] rdata;
  logic [NUM_RD-1:0]            rbusy;

  modport master (
    output clear_req, wen, waddr, wdata, alloc_en, alloc_addr, raddr,
    input  ready, rdata, rbusy
  );

  modport slave (
    input  clear_req, wen, waddr, wdata, alloc_en, alloc_addr, raddr,
    output ready, rdata, rbusy
  );
endinterface

// File: rtl/rf_multiport_sb_clear_fsm.sv
// rtl/rf_multiport_sb_clear_fsm.sv - sequential bulk-clear engine
// Walks entries 1..2**AW-1 writing zero, then hands the array over to RUN.
module rf_multiport_sb_clear_fsm
  import rf_multiport_sb_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear_req,
  output logic                  o_ready,
  output logic                  o_clr_we,
  output logic [ADDR_WIDTH-1:0] o_clr_addr
);

  rf_state_t             r_state;
  logic [ADDR_WIDTH-1:0] r_clr_ptr;
  logic                  r_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RF_ST_CLEAR;
      r_clr_ptr <= ADDR_WIDTH'(1);
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        RF_ST_CLEAR: begin
          // The pointer wraps to 0 exactly as the last entry is written.
          r_clr_ptr <= r_clr_ptr + ADDR_WIDTH'(1);
          if (&r_clr_ptr) begin
            r_state <= RF_ST_RUN;
            r_ready <= 1'b1;
          end
        end
        RF_ST_RUN: begin
          if (i_clear_req) begin
            r_state   <= RF_ST_CLEAR;
            r_clr_ptr <= ADDR_WIDTH'(1);
            r_ready   <= 1'b0;
          end
        end
        default: begin
          r_state <= RF_ST_CLEAR;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready    = r_ready;
  assign o_clr_we   = (r_state == RF_ST_CLEAR);
  assign o_clr_addr = r_clr_ptr;

endmodule

// File: rtl/rf_multiport_sb.sv
// rtl/rf_multiport_sb.sv - multi-port register file with busy scoreboard
// Array has no reset; the clear engine zeroes it after reset or on request.
module rf_multiport_sb
  import rf_multiport_sb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int BYPASS     = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  rf_multiport_sb_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]      r_busy;
  logic [DEPTH-1:0]      w_busy_nxt;
  logic                  w_clr_we;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_run;
  logic [ADDR_WIDTH-1:0] w_waddr [NUM_WR];
  logic [DATA_WIDTH-1:0] w_wdata [NUM_WR];

  rf_multiport_sb_clear_fsm #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear_req(bus.clear_req),
    .o_ready    (bus.ready),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  assign w_run = ~w_clr_we;

  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
    assign w_waddr[k] = bus.waddr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata[k] = bus.wdata[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Later loop iterations override earlier ones, giving the higher port priority.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_regs[w_clr_addr] <= '0;
    end else if (!bus.clear_req) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (bus.wen[k] && (w_waddr[k] != '0)) begin
          r_regs[w_waddr[k]] <= w_wdata[k];
        end
      end
    end
  end

  // Alloc is applied after the write clears so a new producer wins.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int k = 0; k < NUM_WR; k++) begin
      if (bus.wen[k]) w_busy_nxt[w_waddr[k]] = 1'b0;
    end
    if (bus.alloc_en) w_busy_nxt[bus.alloc_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else if (w_clr_we || bus.clear_req) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_ra;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_fwd;
    logic [DATA_WIDTH-1:0] w_rd;
    logic                  w_rb;

    assign w_ra = bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      w_hit = 1'b0;
      w_fwd = '0;
      if (BYPASS != 0) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (bus.wen[k] && (w_waddr[k] == w_ra)) begin
            w_hit = 1'b1;
            w_fwd = w_wdata[k];
          end
        end
      end
      if (!w_run || (w_ra == '0)) begin
        w_rd = '0;
        w_rb = 1'b0;
      end else if (w_hit) begin
        w_rd = w_fwd;
        w_rb = 1'b0;
      end else begin
        w_rd = r_regs[w_ra];
        w_rb = r_busy[w_ra];
      end
    end

    assign bus.rdata[i*DATA_WIDTH +: DATA_WIDTH] = w_rd;
    assign bus.rbusy[i] = w_rb;
  end

endmodule

// File: tb/tb_rf_multiport_sb.sv
// tb/tb_rf_multiport_sb.sv - directed bench for rf_multiport_sb
// Runs a bypass and a non-bypass instance side by side on the same stimulus.
module tb_rf_multiport_sb;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   n_cyc;

  rf_multiport_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(2)) ifb ();
  rf_multiport_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(2)) ifn ();

  rf_multiport_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifb.slave)
  );

  rf_multiport_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) dut_n (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifn.slave)
  );

  assign ifn.clear_req  = ifb.clear_req;
  assign ifn.wen        = ifb.wen;
  assign ifn.waddr      = ifb.waddr;
  assign ifn.wdata      = ifb.wdata;
  assign ifn.alloc_en   = ifb.alloc_en;
  assign ifn.alloc_addr = ifb.alloc_addr;
  assign ifn.raddr      = ifb.raddr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ifb.ready && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic idle();
    ifb.clear_req  = 1'b0;
    ifb.wen        = 2'b00;
    ifb.waddr      = '0;
    ifb.wdata      = '0;
    ifb.alloc_en   = 1'b0;
    ifb.alloc_addr = '0;
  endtask

  task automatic check_all_zero(input string tag);
    int bad_d;
    int bad_b;
    bad_d = 0;
    bad_b = 0;
    for (int a = 0; a < 32; a++) begin
      ifb.raddr = {5'(31 - a), 5'(a)};
      #1;
      if (ifb.rdata !== 64'h0 || ifn.rdata !== 64'h0) bad_d++;
      if (ifb.rbusy !== 2'b00 || ifn.rbusy !== 2'b00) bad_b++;
    end
    chk({tag, "_rdata_nonzero"}, 32'(bad_d), 32'd0);
    chk({tag, "_rbusy_nonzero"}, 32'(bad_b), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    idle();
    ifb.raddr = '0;

    // Reset and initial clear.
    #3;
    chk("reset_ready_b", 32'(ifb.ready), 32'd0);
    chk("reset_ready_n", 32'(ifn.ready), 32'd0);
    chk("reset_rdata", ifb.rdata[31:0], 32'h0);
    #14;
    rst_n = 1'b1;
    wait_ready(n_cyc);
    chk("init_clear_cycles", 32'(n_cyc), 32'd31);
    chk("init_ready_n", 32'(ifn.ready), 32'd1);
    check_all_zero("init");

    // Single write: bypass sees it now, non-bypass next cycle.
    ifb.raddr = {5'd0, 5'd5};
    ifb.wen   = 2'b01;
    ifb.waddr = {5'd0, 5'd5};
    ifb.wdata = {32'h0, 32'hDEADBEEF};
    #1;
    chk("wr_same_cycle_b", ifb.rdata[31:0], 32'hDEADBEEF);
    chk("wr_same_cycle_n", ifn.rdata[31:0], 32'h0);
    step();
    idle();
    #1;
    chk("wr_next_cycle_b", ifb.rdata[31:0], 32'hDEADBEEF);
    chk("wr_next_cycle_n", ifn.rdata[31:0], 32'hDEADBEEF);

    // Both ports to reg7: port 1 wins.
    ifb.raddr = {5'd7, 5'd5};
    ifb.wen   = 2'b11;
    ifb.waddr = {5'd7, 5'd7};
    ifb.wdata = {32'd2, 32'd1};
    #1;
    chk("prio_bypass_b", ifb.rdata[63:32], 32'd2);
    step();
    idle();
    #1;
    chk("prio_reg7_b", ifb.rdata[63:32], 32'd2);
    chk("prio_reg7_n", ifn.rdata[63:32], 32'd2);
    chk("prio_reg5_kept", ifn.rdata[31:0], 32'hDEADBEEF);

    // Writes to reg0 are discarded.
    ifb.raddr = {5'd0, 5'd0};
    ifb.wen   = 2'b01;
    ifb.waddr = {5'd0, 5'd0};
    ifb.wdata = {32'h0, 32'hFFFFFFFF};
    #1;
    chk("reg0_same_b", ifb.rdata[31:0], 32'h0);
    step();
    idle();
    #1;
    chk("reg0_after_b", ifb.rdata[31:0], 32'h0);
    chk("reg0_after_n", ifn.rdata[31:0], 32'h0);

    // Scoreboard: alloc, then write releases.
    ifb.raddr      = {5'd0, 5'd3};
    ifb.alloc_en   = 1'b1;
    ifb.alloc_addr = 5'd3;
    step();
    idle();
    #1;
    chk("sb_alloc_b", 32'(ifb.rbusy[0]), 32'd1);
    chk("sb_alloc_n", 32'(ifn.rbusy[0]), 32'd1);
    ifb.wen   = 2'b01;
    ifb.waddr = {5'd0, 5'd3};
    ifb.wdata = {32'h0, 32'h33};
    #1;
    chk("sb_wr_same_b", 32'(ifb.rbusy[0]), 32'd0);
    chk("sb_wr_same_n", 32'(ifn.rbusy[0]), 32'd1);
    step();
    idle();
    #1;
    chk("sb_wr_after_b", 32'(ifb.rbusy[0]), 32'd0);
    chk("sb_wr_after_n", 32'(ifn.rbusy[0]), 32'd0);

    // Alloc and write in the same cycle: busy ends set.
    ifb.wen        = 2'b10;
    ifb.waddr      = {5'd3, 5'd0};
    ifb.wdata      = {32'h44, 32'h0};
    ifb.alloc_en   = 1'b1;
    ifb.alloc_addr = 5'd3;
    step();
    idle();
    #1;
    chk("sb_alloc_wr_b", 32'(ifb.rbusy[0]), 32'd1);
    chk("sb_alloc_wr_n", 32'(ifn.rbusy[0]), 32'd1);
    chk("sb_alloc_wr_data", ifn.rdata[31:0], 32'h44);

    // Fill 1..31, then clear on request.
    for (int a = 1; a < 32; a++) begin
      ifb.wen   = 2'b01;
      ifb.waddr = {5'd0, 5'(a)};
      ifb.wdata = {32'h0, 32'(a) * 32'h01010101};
      step();
    end
    idle();
    ifb.alloc_en   = 1'b1;
    ifb.alloc_addr = 5'd4;
    step();
    idle();
    ifb.raddr = {5'd4, 5'd31};
    #1;
    chk("fill_reg31_n", ifn.rdata[31:0], 32'h1F1F1F1F);
    chk("fill_busy4_n", 32'(ifn.rbusy[1]), 32'd1);

    ifb.clear_req  = 1'b1;
    ifb.wen        = 2'b01;
    ifb.waddr      = {5'd0, 5'd9};
    ifb.wdata      = {32'h0, 32'h0000DEAD};
    ifb.alloc_en   = 1'b1;
    ifb.alloc_addr = 5'd5;
    step();
    ifb.clear_req = 1'b0;
    chk("clr_ready_drop", 32'(ifb.ready), 32'd0);
    chk("clr_rdata_zero", ifb.rdata[31:0], 32'h0);
    wait_ready(n_cyc);
    idle();
    chk("clr_cycles", 32'(n_cyc), 32'd31);
    check_all_zero("clr");

    // Async reset: immediate drop in RUN, then a restart mid-clear.
    rst_n = 1'b0;
    #1;
    chk("arst_ready_b", 32'(ifb.ready), 32'd0);
    chk("arst_ready_n", 32'(ifn.ready), 32'd0);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) step();
    chk("arst_mid_ready", 32'(ifb.ready), 32'd0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    wait_ready(n_cyc);
    chk("arst_restart_cycles", 32'(n_cyc), 32'd31);
    check_all_zero("arst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
